// File: rtl/ex_sequencer_if.sv
// ex_sequencer_if: handshake and data bundle between the ID stage, the
// ex_sequencer, the ALU/condition tester, data memory and write-back.
//   master : instruction issuer / surrounding datapath (drives the instruction
//            fields, ALU flags, condition result and wb_ready)
//   slave  : ex_sequencer (drives ex_ready, rf_flags, dm strobes, wb_valid,
//            wb_taken)
interface ex_sequencer_if;
  logic       id_valid;
  logic       ex_ready;
  logic [1:0] uc_CLASS;
  logic       uc_WF;
  logic [3:0] alu_flags;
  logic       tf_out;
  logic [3:0] rf_flags;
  logic       dm_read_file;
  logic       dm_write_file;
  logic       wb_valid;
  logic       wb_ready;
  logic       wb_taken;

  modport master (
    output id_valid, uc_CLASS, uc_WF, alu_flags, tf_out, wb_ready,
    input  ex_ready, rf_flags, dm_read_file, dm_write_file, wb_valid, wb_taken
  );

  modport slave (
    input  id_valid, uc_CLASS, uc_WF, alu_flags, tf_out, wb_ready,
    output ex_ready, rf_flags, dm_read_file, dm_write_file, wb_valid, wb_taken
  );
endinterface

// File: rtl/ex_sequencer.sv
// ex_sequencer: multi-cycle EX-stage controller. Accepts one decoded
// instruction at a time (IDLE), runs a one-cycle EXEC step, holds the
// data-memory strobe for MEM_LAT cycles on loads/stores (MEM), then offers a
// single write-back handshake (DONE). Owns the {O,S,C,Z} flag register.
// All outputs are registered.
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   bus          ex_sequencer_if.slave (instruction in, flags, dm strobes, wb)
//   ex_busy_cnt  only with EX_PERF_CNT_EN defined: saturating count of
//                non-IDLE cycles
// Parameters: MEM_LAT (1..15) memory access cycles, CNT_W wait counter width.
// Optional feature macro: EX_PERF_CNT_EN.
module ex_sequencer #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic CLK,
  input  logic RST,
  ex_sequencer_if.slave bus
`ifdef EX_PERF_CNT_EN
  ,
  output logic [15:0] ex_busy_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, DONE} state_t;
  typedef enum logic [1:0] {CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH} class_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_t           r_state;
  class_t           r_class;
  logic             r_wf;
  logic [3:0]       r_flags;
  logic             r_ready;
  logic             r_rd;
  logic             r_wr;
  logic             r_wbv;
  logic             r_taken;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_class <= CL_ALU;
      r_wf    <= 1'b0;
      r_flags <= '0;
      r_ready <= 1'b1;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_wbv   <= 1'b0;
      r_taken <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.id_valid) begin
            r_class <= class_t'(bus.uc_CLASS);
            r_wf    <= bus.uc_WF;
            r_ready <= 1'b0;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          case (r_class)
            CL_ALU: begin
              if (r_wf) r_flags <= bus.alu_flags;
              r_wbv   <= 1'b1;
              r_state <= DONE;
            end
            CL_BRANCH: begin
              r_taken <= bus.tf_out;
              r_wbv   <= 1'b1;
              r_state <= DONE;
            end
            CL_LOAD, CL_STORE: begin
              // Strobe is registered here so it is high from the first MEM cycle.
              r_cnt   <= CNT_INIT;
              r_rd    <= (r_class == CL_LOAD);
              r_wr    <= (r_class == CL_STORE);
              r_state <= MEM;
            end
          endcase
        end
        MEM: begin
          if (r_cnt == '0) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_wbv   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.wb_ready) begin
            r_wbv   <= 1'b0;
            r_taken <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ex_ready      = r_ready;
  assign bus.rf_flags      = r_flags;
  assign bus.dm_read_file  = r_rd;
  assign bus.dm_write_file = r_wr;
  assign bus.wb_valid      = r_wbv;
  assign bus.wb_taken      = r_taken;

`ifdef EX_PERF_CNT_EN
  logic [15:0] r_busy_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_busy_cnt <= '0;
    end else if (r_state != IDLE && r_busy_cnt != '1) begin
      r_busy_cnt <= r_busy_cnt + 16'd1;
    end
  end

  assign ex_busy_cnt = r_busy_cnt;
`endif

endmodule

// File: tb/tb_ex_sequencer.sv
module tb_ex_sequencer;
  localparam int MEM_LAT = 2;
  localparam logic [1:0] C_ALU = 2'b00, C_LOAD = 2'b01, C_STORE = 2'b10, C_BR = 2'b11;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ex_sequencer_if u_if ();

`ifdef EX_PERF_CNT_EN
  logic [15:0] busy_cnt;
`endif

  ex_sequencer #(.MEM_LAT(MEM_LAT), .CNT_W(4)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (u_if.slave)
`ifdef EX_PERF_CNT_EN
    ,
    .ex_busy_cnt (busy_cnt)
`endif
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] cls;
    logic       wf;
    logic [3:0] fl;
    logic       tf;
    int         stall;
    int         lat;
    logic       taken;
    logic [3:0] flags;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one instruction and follow it to the end of its write-back.
  // Unrelated id_valid/wb_ready/instruction noise is driven while busy.
  task automatic run_op(input logic [1:0] cls, input logic wf, input logic [3:0] fl,
                        input logic tf, input int stall, input int exp_lat,
                        input logic exp_taken, input logic [3:0] exp_flags);
    int  wb_first = -1, wbv_n = 0, rd_n = 0, wr_n = 0, sfirst = -1, bad = 0, dn = 0;
    bit  done = 0;
    bit  is_mem;
    is_mem = (cls == C_LOAD) || (cls == C_STORE);
    @(negedge CLK);
    chk("ready_at_issue", int'(u_if.ex_ready), 1);
    u_if.id_valid  = 1'b1;
    u_if.uc_CLASS  = cls;
    u_if.uc_WF     = wf;
    u_if.alu_flags = fl;
    u_if.tf_out    = tf;
    u_if.wb_ready  = 1'($urandom_range(0, 1));
    @(posedge CLK);
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge CLK);
      if (u_if.ex_ready) bad++;
      if (u_if.dm_read_file && u_if.dm_write_file) bad++;
      if (u_if.dm_read_file)  begin rd_n++; if (sfirst < 0) sfirst = k; end
      if (u_if.dm_write_file) begin wr_n++; if (sfirst < 0) sfirst = k; end
      u_if.id_valid = 1'($urandom_range(0, 1));
      u_if.uc_CLASS = 2'($urandom_range(0, 3));
      u_if.uc_WF    = 1'($urandom_range(0, 1));
      if (k >= 2) begin
        u_if.alu_flags = 4'($urandom_range(0, 15));
        u_if.tf_out    = 1'($urandom_range(0, 1));
      end
      if (u_if.wb_valid) begin
        wbv_n++;
        dn++;
        if (wb_first < 0) begin
          wb_first = k;
          chk("flags_at_wb", int'(u_if.rf_flags), int'(exp_flags));
          chk("taken_at_wb", int'(u_if.wb_taken), int'(exp_taken));
        end
        u_if.wb_ready = (dn > stall);
        if (u_if.wb_ready) begin
          u_if.id_valid = 1'b0;
          done = 1;
        end
      end else begin
        u_if.wb_ready = 1'($urandom_range(0, 1));
      end
    end
    chk("wb_handshake_seen", int'(done), 1);
    chk("wb_latency", wb_first, exp_lat);
    chk("wb_valid_cycles", wbv_n, stall + 1);
    chk("read_strobe_cycles", rd_n, (cls == C_LOAD) ? MEM_LAT : 0);
    chk("write_strobe_cycles", wr_n, (cls == C_STORE) ? MEM_LAT : 0);
    chk("strobe_first_cycle", sfirst, is_mem ? 2 : -1);
    chk("busy_violations", bad, 0);
    @(negedge CLK);
    u_if.wb_ready = 1'b0;
    chk("ready_after_wb", int'(u_if.ex_ready), 1);
    chk("wb_valid_cleared", int'(u_if.wb_valid), 0);
    chk("wb_taken_cleared", int'(u_if.wb_taken), 0);
    chk("flags_after_wb", int'(u_if.rf_flags), int'(exp_flags));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, int'(u_if.ex_ready), 1);
    chk({tag, "_flags"}, int'(u_if.rf_flags), 0);
    chk({tag, "_rd"}, int'(u_if.dm_read_file), 0);
    chk({tag, "_wr"}, int'(u_if.dm_write_file), 0);
    chk({tag, "_wbv"}, int'(u_if.wb_valid), 0);
    chk({tag, "_taken"}, int'(u_if.wb_taken), 0);
`ifdef EX_PERF_CNT_EN
    chk({tag, "_busy_cnt"}, int'(busy_cnt), 0);
`endif
  endtask

  initial begin
    logic [3:0] mflags;
    logic [1:0] cls;
    logic       wf, tf, taken;
    logic [3:0] fl;
    int         stall, lat;

    u_if.id_valid = 0; u_if.uc_CLASS = 0; u_if.uc_WF = 0;
    u_if.alu_flags = 0; u_if.tf_out = 0; u_if.wb_ready = 0;

    tbl[0] = '{C_ALU,   1'b1, 4'b1010, 1'b0, 0, 2,           1'b0, 4'b1010};
    tbl[1] = '{C_LOAD,  1'b1, 4'b1111, 1'b1, 0, 2 + MEM_LAT, 1'b0, 4'b1010};
    tbl[2] = '{C_STORE, 1'b0, 4'b0000, 1'b0, 5, 2 + MEM_LAT, 1'b0, 4'b1010};
    tbl[3] = '{C_ALU,   1'b0, 4'b0101, 1'b0, 0, 2,           1'b0, 4'b1010};
    tbl[4] = '{C_BR,    1'b1, 4'b0110, 1'b1, 0, 2,           1'b1, 4'b1010};
    tbl[5] = '{C_BR,    1'b0, 4'b1111, 1'b0, 1, 2,           1'b0, 4'b1010};
    tbl[6] = '{C_ALU,   1'b1, 4'b0011, 1'b0, 2, 2,           1'b0, 4'b0011};
    tbl[7] = '{C_BR,    1'b0, 4'b1100, 1'b1, 0, 2,           1'b1, 4'b0011};

    repeat (2) @(negedge CLK);
    chk_reset_outputs("reset");
    RST = 1'b0;

    foreach (tbl[i])
      run_op(tbl[i].cls, tbl[i].wf, tbl[i].fl, tbl[i].tf, tbl[i].stall,
             tbl[i].lat, tbl[i].taken, tbl[i].flags);

    // Reset in the first MEM cycle of a STORE abandons the access at once.
    @(negedge CLK);
    u_if.id_valid = 1'b1; u_if.uc_CLASS = C_STORE; u_if.uc_WF = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    u_if.id_valid = 1'b0;
    @(negedge CLK);
    chk("mid_store_write_strobe", int'(u_if.dm_write_file), 1);
    #2 RST = 1'b1;
    #1 chk_reset_outputs("mid_mem_reset");
    @(negedge CLK);
    RST = 1'b0;
    run_op(C_ALU, 1'b1, 4'b1100, 1'b0, 0, 2, 1'b0, 4'b1100);

    // Randomized instructions against the architectural model.
    mflags = 4'b1100;
    for (int n = 0; n < 40; n++) begin
      cls   = 2'($urandom_range(0, 3));
      wf    = 1'($urandom_range(0, 1));
      fl    = 4'($urandom_range(0, 15));
      tf    = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      lat   = (cls == C_LOAD || cls == C_STORE) ? 2 + MEM_LAT : 2;
      taken = (cls == C_BR) ? tf : 1'b0;
      if (cls == C_ALU && wf) mflags = fl;
      run_op(cls, wf, fl, tf, stall, lat, taken, mflags);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
